bcd_scan_mux: RTL
=================

// Module: bcd_scan_mux
// PURPOSE
//  Time-multiplexed digit scanner sitting directly upstream of the BCD-to-7-segment decoder.
//  - Accepts a packed multi-digit BCD word through a load/ready handshake.
//  - Presents one 4-bit digit at a time on dout, which feeds the decoder's din.
//  - Drives an active-low one-hot digit select for a common-anode display.
//  - Blanks leading zeros and inserts a dead cycle between digits to suppress ghosting.
// PARAMETERS
//  DIGITS   4      number of display digits (>=2)
//  DIV      50000  clk cycles per digit slot (>=3)
//  BLANK_LZ 1      1 = blank leading zeros; 0 = show all digits
// PORTS
//  clk    in   1         system clock, rising edge
//  rst    in   1         synchronous, active-high reset
//  din    in   4*DIGITS  packed BCD word; digit 0 = din[3:0] = least significant
//  load   in   1         request to update the displayed value
//  ready  out  1         1 = load is accepted this cycle
//  dout   out  4         current digit code to the decoder; 4'hF = blank
//  sel    out  DIGITS    active-low digit enable, one-hot-low or all ones
// BEHAVIOUR
//  Reset
//  - prescaler=0, idx=0, shown=0, pend=0, pending=0.
//  - ready=1, dout=4'hF, sel=all ones.
//  - Reset mid-frame or mid-handshake discards any pending value.
//  Prescaler
//  - cnt counts 0..DIV-1 and wraps.
//  - tick asserts for one cycle when cnt==DIV-1.
//  - On tick, idx advances and wraps DIGITS-1 -> 0.
//  - Frame boundary = tick while idx==DIGITS-1.
//  Handshake
//  - Accept = load && ready: pend<=din, pending<=1, ready falls on the next cycle.
//  - load while ready=0 is ignored; the value is not queued.
//  - At a frame boundary with pending=1: shown<=pend, pending<=0, ready rises on the next cycle.
//  - An accept in the same cycle as a boundary is applied at the following boundary, not this one.
//  - A displayed value therefore never changes mid-frame.
//  Outputs (registered, one cycle after the state that produces them)
//  - Dead cycle: in the cycle cnt==0, sel=all ones and dout=4'hF.
//  - Otherwise sel[idx]=0 with all other bits 1, and dout=shown digit idx, unless blanked.
//  - Blanking: when BLANK_LZ=1, digit i>0 is blanked if it and every more-significant digit are 0.
//  - A blanked digit gives dout=4'hF, sel still asserted for it; the decoder outputs all-off for 4'hF.
//  - Digit 0 is never blanked, so a value of 0 displays "0".
//  - Non-BCD nibbles (A-E) pass through unchanged; the decoder renders them dark.
//    They do not count as zero for blanking.
//  - Slot timing: each digit has DIV cycles per slot, 1 of them dead, so a full frame is DIGITS*DIV cycles.
// STRUCTURE
//  - Shared package: BLANK_CODE=4'hF, SEL_OFF all-ones, digit width constant 4.
//  - One sub-module, tick_div (parameter DIV): prescaler producing the tick and cnt==0 flag.
//  - Handshake, idx counter, blank mask and output registers live in this module.
// TESTING (DIGITS=4, DIV=4 unless stated)
//  1. Reset, no load.
//     -> ready=1; sel cycles 1110,1101,1011,0111 with a 1111 dead cycle per slot.
//     -> dout=0 on digit 0 and 4'hF on digits 1-3.
//  2. load din=16'h1234 at idle.
//     -> ready=0 the next cycle.
//     -> After the next frame boundary: digits show 4,3,2,1 and ready returns to 1.
//  3. din=16'h0050 with BLANK_LZ=1.
//     -> digits 3 and 2 give dout=F, digit 1=5, digit 0=0.
//     -> With BLANK_LZ=0, digits 3 and 2 give dout=0.
//  4. load 16'h1111 then load 16'h2222 while ready=0.
//     -> 1111 is displayed; 2222 is never displayed.
//  5. load asserted exactly in the boundary cycle.
//     -> Old value is held for one more full frame (16 cycles), then the new value appears.
//  6. rst asserted mid-slot after a load of 16'h9876.
//     -> Next cycle: sel=1111, dout=F, ready=1, shown=0.
//     -> The pending 9876 is never displayed.

Source files
------------

// File: rtl/bcd_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_scan_mux_pkg
//  Brief   : Shared constants for the BCD digit scanner.
//  Rev     : 1.0
// ============================================================================
package bcd_scan_mux_pkg;

    localparam int                 DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    localparam logic [DIGIT_W-1:0] ZERO_CODE  = 4'h0;
    // Sliced down to the digit count by users; all ones means no digit enabled.
    localparam logic [63:0]        SEL_OFF    = '1;

endpackage : bcd_scan_mux_pkg
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
//  Module  : tick_div
//  Brief   : Slot prescaler; tick on the last count, zero flag on the first.
//  Rev     : 1.0
// ============================================================================
module tick_div #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o,
    output logic zero_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_W'(DIV - 1));
    assign zero_o = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule : tick_div
`default_nettype wire

// File: rtl/bcd_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_scan_mux
//  Brief   : Multiplexed BCD digit scanner with leading-zero blanking,
//            dead cycle per slot and frame-aligned value updates.
//  Rev     : 1.0
// ============================================================================
module bcd_scan_mux
    import bcd_scan_mux_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV      = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIGIT_W*DIGITS-1:0]   din,
    input  logic                        load,
    output logic                        ready,
    output logic [DIGIT_W-1:0]          dout,
    output logic [DIGITS-1:0]           sel
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int W     = DIGIT_W * DIGITS;

    logic               w_tick;
    logic               w_slot_start;
    logic               w_last;
    logic               w_boundary;
    logic               w_accept;
    logic               w_zero_run;
    logic [DIGITS-1:0]  w_blank;
    logic [DIGIT_W-1:0] w_cur;
    logic               w_cur_blank;

    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [W-1:0]       shown_q,   shown_d;
    logic [W-1:0]       pend_q,    pend_d;
    logic               pending_q, pending_d;
    logic               ready_q,   ready_d;
    logic [DIGIT_W-1:0] dout_q,    dout_d;
    logic [DIGITS-1:0]  sel_q,     sel_d;

    tick_div #(
        .DIV    (DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .tick_o (w_tick),
        .zero_o (w_slot_start)
    );

    assign w_last     = (idx_q == IDX_W'(DIGITS - 1));
    assign w_boundary = w_tick && w_last;
    assign w_accept   = load && ready_q;

    // ready is always the inverse of pending, so accept and commit never coincide.
    always_comb begin
        idx_d     = idx_q;
        shown_d   = shown_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        if (w_tick) begin
            idx_d = w_last ? '0 : idx_q + IDX_W'(1);
        end
        if (w_boundary && pending_q) begin
            shown_d   = pend_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end
        if (w_accept) begin
            pend_d    = din;
            pending_d = 1'b1;
            ready_d   = 1'b0;
        end
    end

    always_comb begin
        w_zero_run  = 1'b1;
        w_blank     = '0;
        w_cur       = ZERO_CODE;
        w_cur_blank = 1'b0;
        sel_d       = SEL_OFF[DIGITS-1:0];
        dout_d      = BLANK_CODE;
        // Walk from the most significant digit down, tracking the run of zeros.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (shown_q[i*DIGIT_W +: DIGIT_W] == ZERO_CODE);
            w_blank[i] = (BLANK_LZ != 0) && (i != 0) && w_zero_run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_cur       = shown_q[i*DIGIT_W +: DIGIT_W];
                w_cur_blank = w_blank[i];
                sel_d[i]    = 1'b0;
            end
        end
        if (w_slot_start) begin
            sel_d  = SEL_OFF[DIGITS-1:0];
            dout_d = BLANK_CODE;
        end else begin
            dout_d = w_cur_blank ? BLANK_CODE : w_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            shown_q   <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            dout_q    <= BLANK_CODE;
            sel_q     <= SEL_OFF[DIGITS-1:0];
        end else begin
            idx_q     <= idx_d;
            shown_q   <= shown_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            dout_q    <= dout_d;
            sel_q     <= sel_d;
        end
    end

    assign ready = ready_q;
    assign dout  = dout_q;
    assign sel   = sel_q;

endmodule : bcd_scan_mux
`default_nettype wire
